if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
//  - Owns the PC.
//  - Fetches from an instruction memory with a variable-latency req/ack handshake.
//  - Honours stall_IF/flush_ID from the hazard unit and branch/jump redirects from EX.
//  - Delivers instr_ID/PC_ID/valid_ID to decode.

---
 rtl/if_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// if_stage : instruction fetch stage plus IF/ID pipeline register.
//
// Owns the PC, fetches from instruction memory over a req/ack handshake of
// variable latency, and presents instr_ID / PC_ID / valid_ID to decode.
// Reacts to stall_IF / flush_ID from the hazard unit and to redirects from EX.
//
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt / bubble_cnt
// performance counters. Without it those ports and their logic are absent.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_REQ   | request for pc outstanding; a response may be used directly
// S_DRAIN | old request still outstanding but its result is unwanted;
//         | the redirect target waits in pending_pc
// S_HOLD  | a fetched word sits in hold_buf because IF/ID could not take it
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        flush_ID,
    input  logic        redirect_EX,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_ID,
    output logic        valid_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pending_pc;
    logic [31:0] pending_nxt;
    logic [31:0] hold_buf;
    logic [31:0] hold_nxt;

    logic [31:0] redir_tgt;
    logic        ack_eff;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic        load_bubble;

    // Redirect targets are always word aligned.
    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    // Request is a pure function of state; reset kills it combinationally so
    // an abandoned request disappears in the same cycle rst rises.
    assign imem_req  = ((state == S_REQ) || (state == S_DRAIN)) && !rst;
    assign imem_addr = pc;

    // An ack without an outstanding request is meaningless and ignored.
    assign ack_eff = imem_ack && imem_req;

    // Bubble covers both an explicit flush and an idle cycle without a stall.
    // A flush always wins, even over a stall.
    assign load_bubble = flush_ID || (!stall_IF && !deliver);

    // State register and the fetch-side datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            pending_pc <= 32'h0;
            hold_buf   <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
            hold_buf   <= hold_nxt;
        end
    end

    // Next-state, next-PC and delivery decision.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pending_nxt   = pending_pc;
        hold_nxt      = hold_buf;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;

        case (state)
            S_REQ: begin
                if (ack_eff) begin
                    if (redirect_EX) begin
                        // Fetched word is on the wrong path; refetch at target.
                        pc_nxt = redir_tgt;
                    end else if (stall_IF || flush_ID) begin
                        // IF/ID is busy; park the word so it is not lost.
                        hold_nxt  = imem_rdata;
                        state_nxt = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end else if (redirect_EX) begin
                    // Memory still owes us a word for pc; keep the address
                    // stable and drain it before switching to the target.
                    pending_nxt = redir_tgt;
                    state_nxt   = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (redirect_EX) begin
                    pending_nxt = redir_tgt;
                end
                if (ack_eff) begin
                    pc_nxt    = redirect_EX ? redir_tgt : pending_pc;
                    state_nxt = S_REQ;
                end
            end

            S_HOLD: begin
                deliver_instr = hold_buf;
                if (redirect_EX) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = S_REQ;
                end else if (!stall_IF && !flush_ID) begin
                    deliver   = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase

        if (deliver) begin
            pc_nxt = pc + 32'd4;
        end
    end

    // IF/ID pipeline register: flush > stall (hold) > deliver > bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ID <= NOP_INSTR;
            PC_ID    <= 32'h0;
            valid_ID <= 1'b0;
        end else if (load_bubble) begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (deliver) begin
            instr_ID <= deliver_instr;
            PC_ID    <= pc;
            valid_ID <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters; a held IF/ID register counts as neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else begin
            if (deliver) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (load_bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
